// File: rtl/vga_box_pkg.sv
// Shared constants and FSM encoding for the bouncing-box motion sequencer.
// X_LIM/Y_LIM are the largest top-left coordinates that keep the box on screen.
package vga_box_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int SIZE  = 200;

  localparam int X_LIM = H_RES - SIZE - 1;
  localparam int Y_LIM = V_RES - SIZE - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/box_axis_step.sv
// One-axis position/direction update with reflection at 0 and at lim.
// Purely combinational; the sequencer time-shares a single instance between X and Y.
module box_axis_step #(
  parameter int POS_W = 10,
  parameter int SPD_W = 4
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  input  logic [SPD_W-1:0] spd,
  input  logic [POS_W-1:0] lim,
  output logic [POS_W-1:0] npos,
  output logic             ndir,
  output logic             bounce
);

  // One extra bit so pos + spd cannot wrap before the limit compare.
  logic [POS_W:0] pos_w;
  logic [POS_W:0] spd_w;
  logic [POS_W:0] lim_w;
  logic [POS_W:0] sum;
  logic [POS_W:0] diff;

  assign pos_w = {1'b0, pos};
  assign spd_w = (POS_W+1)'(spd);
  assign lim_w = {1'b0, lim};
  assign sum   = pos_w + spd_w;
  assign diff  = pos_w - spd_w;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    npos   = pos;
    ndir   = dir;
    bounce = 1'b0;
    if (spd != '0) begin
      if (!dir) begin
        if (sum >= lim_w) begin
          npos   = lim;
          ndir   = 1'b1;
          bounce = 1'b1;
        end else begin
          npos = sum[POS_W-1:0];
        end
      end else begin
        if (pos_w <= spd_w) begin
          npos   = '0;
          ndir   = 1'b0;
          bounce = 1'b1;
        end else begin
          npos = diff[POS_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/box_motion_ctrl.sv
// Per-frame box motion sequencer: paces updates off vsync, computes X then Y
// through one shared axis unit, and commits both axes on the same edge.
module box_motion_ctrl #(
  parameter int H_RES = vga_box_pkg::H_RES,
  parameter int V_RES = vga_box_pkg::V_RES,
  parameter int SIZE  = vga_box_pkg::SIZE,
  parameter int POS_W = 10,
  parameter int SPD_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
  input  logic [SPD_W-1:0] speed,
  input  logic [1:0]       frame_div,
  input  logic             pause,
  input  logic             step,
  output logic [POS_W-1:0] box_x,
  output logic [POS_W-1:0] box_y,
  output logic             dir_x,
  output logic             dir_y,
  output logic             bounce_x,
  output logic             bounce_y,
  output logic             busy
);

  import vga_box_pkg::state_e;
  import vga_box_pkg::IDLE;
  import vga_box_pkg::CALC_X;
  import vga_box_pkg::CALC_Y;
  import vga_box_pkg::COMMIT;

  localparam logic [POS_W-1:0] X_LIM = POS_W'(H_RES - SIZE - 1);
  localparam logic [POS_W-1:0] Y_LIM = POS_W'(V_RES - SIZE - 1);

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [1:0]       fcnt_q, fcnt_d;
  logic             step_pend_q, step_pend_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic [POS_W-1:0] nx_q, nx_d, ny_q, ny_d;
  logic             ndx_q, ndx_d, ndy_q, ndy_d;
  logic             bx_q, bx_d, by_q, by_d;
  logic [POS_W-1:0] box_x_q, box_x_d, box_y_q, box_y_d;
  logic             dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic             bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;

  logic             tick;
  logic             launch;
  logic [POS_W-1:0] ax_pos, ax_lim, ax_npos;
  logic             ax_dir, ax_ndir, ax_bounce;

  assign tick = vsync & ~vsync_q;

  // Operand mux: Y operands only while in CALC_Y, X otherwise.
  assign ax_pos = (state_q == CALC_Y) ? box_y_q : box_x_q;
  assign ax_dir = (state_q == CALC_Y) ? dir_y_q : dir_x_q;
  assign ax_lim = (state_q == CALC_Y) ? Y_LIM   : X_LIM;

  box_axis_step #(
    .POS_W(POS_W),
    .SPD_W(SPD_W)
  ) u_axis (
    .pos   (ax_pos),
    .dir   (ax_dir),
    .spd   (spd_q),
    .lim   (ax_lim),
    .npos  (ax_npos),
    .ndir  (ax_ndir),
    .bounce(ax_bounce)
  );

  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    step_pend_d = step_pend_q;
    spd_d       = spd_q;
    nx_d        = nx_q;
    ndx_d       = ndx_q;
    bx_d        = bx_q;
    ny_d        = ny_q;
    ndy_d       = ndy_q;
    by_d        = by_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    bounce_x_d  = 1'b0;
    bounce_y_d  = 1'b0;
    launch      = 1'b0;

    if (!pause)     step_pend_d = 1'b0;
    else if (step)  step_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          if (!pause) begin
            if (fcnt_q >= frame_div) begin
              launch = 1'b1;
              fcnt_d = '0;
            end else begin
              fcnt_d = fcnt_q + 2'd1;
            end
          end else if (step_pend_q) begin
            launch      = 1'b1;
            step_pend_d = 1'b0;
          end
        end
        if (launch) begin
          state_d = CALC_X;
          spd_d   = speed;
        end
      end
      CALC_X: begin
        nx_d    = ax_npos;
        ndx_d   = ax_ndir;
        bx_d    = ax_bounce;
        state_d = CALC_Y;
      end
      CALC_Y: begin
        ny_d    = ax_npos;
        ndy_d   = ax_ndir;
        by_d    = ax_bounce;
        state_d = COMMIT;
      end
      COMMIT: begin
        box_x_d    = nx_q;
        box_y_d    = ny_q;
        dir_x_d    = ndx_q;
        dir_y_d    = ndy_q;
        bounce_x_d = bx_q;
        bounce_y_d = by_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vsync_q     <= 1'b1;
      fcnt_q      <= '0;
      step_pend_q <= 1'b0;
      // NOTE: the in-flight datapath registers are reset too, so a reset mid-update leaves no stale result behind.
      spd_q       <= '0;
      nx_q        <= '0;
      ndx_q       <= 1'b0;
      bx_q        <= 1'b0;
      ny_q        <= '0;
      ndy_q       <= 1'b0;
      by_q        <= 1'b0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      fcnt_q      <= fcnt_d;
      step_pend_q <= step_pend_d;
      spd_q       <= spd_d;
      nx_q        <= nx_d;
      ndx_q       <= ndx_d;
      bx_q        <= bx_d;
      ny_q        <= ny_d;
      ndy_q       <= ndy_d;
      by_q        <= by_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      bounce_x_q  <= bounce_x_d;
      bounce_y_q  <= bounce_y_d;
    end
  end

  assign box_x    = box_x_q;
  assign box_y    = box_y_q;
  assign dir_x    = dir_x_q;
  assign dir_y    = dir_y_q;
  assign bounce_x = bounce_x_q;
  assign bounce_y = bounce_y_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Randomized self-checking bench for box_motion_ctrl against a frame-level
// reference model of pacing, pause/step and the axis reflection rule.
module tb_box_motion_ctrl;

  localparam int POS_W = 10;
  localparam int SPD_W = 4;
  localparam int X_LIM = 439;
  localparam int Y_LIM = 279;

  logic             clk = 1'b0;
  logic             reset;
  logic             vsync;
  logic [SPD_W-1:0] speed;
  logic [1:0]       frame_div;
  logic             pause;
  logic             step;
  logic [POS_W-1:0] box_x, box_y;
  logic             dir_x, dir_y, bounce_x, bounce_y, busy;

  box_motion_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .vsync    (vsync),
    .speed    (speed),
    .frame_div(frame_div),
    .pause    (pause),
    .step     (step),
    .box_x    (box_x),
    .box_y    (box_y),
    .dir_x    (dir_x),
    .dir_y    (dir_y),
    .bounce_x (bounce_x),
    .bounce_y (bounce_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int n_obs  = 0;

  int m_x, m_y, m_dx, m_dy, m_fcnt;
  bit m_step;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic void axis_ref(input int pos, input int dir, input int spd, input int lim,
                                   output int np, output int nd, output int b);
    np = pos; nd = dir; b = 0;
    if (spd != 0) begin
      if (dir == 0) begin
        if (pos + spd >= lim) begin np = lim; nd = 1; b = 1; end
        else np = pos + spd;
      end else begin
        if (pos <= spd) begin np = 0; nd = 0; b = 1; end
        else np = pos - spd;
      end
    end
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_fcnt = 0; m_step = 0;
  endtask

  task automatic check_outputs(input string tag, input int x, input int y,
                               input int dx, input int dy, input int bxv, input int byv, input int bsy);
    check({tag, "_box_x"}, box_x, x);
    check({tag, "_box_y"}, box_y, y);
    check({tag, "_dir_x"}, dir_x, dx);
    check({tag, "_dir_y"}, dir_y, dy);
    check({tag, "_bounce_x"}, bounce_x, bxv);
    check({tag, "_bounce_y"}, bounce_y, byv);
    check({tag, "_busy"}, busy, bsy);
  endtask

  // One frame tick with full cycle-by-cycle checking; model decides launch.
  task automatic do_tick(input bit chg_speed);
    bit launch;
    int nx, ndx, bx, ny, ndy, by;
    launch = 0;
    if (!pause) begin
      if (m_fcnt >= int'(frame_div)) begin launch = 1; m_fcnt = 0; end
      else m_fcnt++;
    end else if (m_step) begin
      launch = 1; m_step = 0;
    end
    nx = m_x; ndx = m_dx; bx = 0; ny = m_y; ndy = m_dy; by = 0;
    if (launch) begin
      axis_ref(m_x, m_dx, int'(speed), X_LIM, nx, ndx, bx);
      axis_ref(m_y, m_dy, int'(speed), Y_LIM, ny, ndy, by);
    end

    @(negedge clk) vsync = 1'b1;
    @(posedge clk) #1;
    if (busy) n_obs++;
    check_outputs("e0", m_x, m_y, m_dx, m_dy, 0, 0, int'(launch));
    if (chg_speed) speed = SPD_W'($urandom);
    for (int e = 1; e <= 2; e++) begin
      @(posedge clk) #1;
      check_outputs("mid", m_x, m_y, m_dx, m_dy, 0, 0, int'(launch));
    end
    @(posedge clk) #1;
    check_outputs("e3", nx, ny, ndx, ndy, bx, by, 0);
    @(posedge clk) #1;
    check("e4_bounce_x", bounce_x, 0);
    check("e4_bounce_y", bounce_y, 0);
    @(negedge clk) vsync = 1'b0;
    repeat (2) @(negedge clk);
    m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
  endtask

  task automatic pulse_step();
    @(negedge clk) step = 1'b1;
    @(negedge clk) step = 1'b0;
    if (pause) m_step = 1;
  endtask

  task automatic set_pause(input bit v);
    @(negedge clk) pause = v;
    @(negedge clk);
    if (!v) m_step = 0;
  endtask

  int obs0;

  initial begin
    reset = 1'b1; vsync = 1'b1; speed = 4'd5; frame_div = 2'd0; pause = 1'b0; step = 1'b0;
    model_reset();
    #23;
    check_outputs("in_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("post_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) vsync = 1'b0;
    repeat (2) @(negedge clk);

    // First update lands at (5,5) three cycles after the tick.
    do_tick(0);
    check("first_x", box_x, 5);
    check("first_y", box_y, 5);

    // March X up to 435, then hit the right wall.
    for (int i = 0; i < 86; i++) do_tick(0);
    check("x_435", box_x, 435);
    do_tick(1);
    check("x_wall", box_x, 439);
    check("x_wall_dir", dir_x, 1);

    // Zero speed holds everything.
    speed = 4'd0;
    do_tick(0);
    do_tick(0);

    // frame_div = 2: exactly three updates in nine ticks.
    speed = 4'd3; frame_div = 2'd2;
    obs0 = n_obs;
    for (int i = 0; i < 9; i++) do_tick(0);
    check("div2_updates", n_obs - obs0, 3);

    // Pause, then a single step, then a cancelled step.
    frame_div = 2'd0;
    set_pause(1);
    obs0 = n_obs;
    for (int i = 0; i < 4; i++) do_tick(0);
    check("paused_updates", n_obs - obs0, 0);
    pulse_step();
    obs0 = n_obs;
    do_tick(0);
    do_tick(0);
    check("step_updates", n_obs - obs0, 1);
    pulse_step();
    set_pause(0);
    set_pause(1);
    obs0 = n_obs;
    do_tick(0);
    do_tick(0);
    check("cleared_step_updates", n_obs - obs0, 0);
    set_pause(0);

    // Randomized mix of speed, pacing, pause and step.
    for (int i = 0; i < 200; i++) begin
      speed = SPD_W'($urandom);
      if ($urandom_range(0, 3) == 0) frame_div = 2'($urandom);
      if ($urandom_range(0, 7) == 0) set_pause(pause ^ 1'b1);
      if ($urandom_range(0, 3) == 0) pulse_step();
      do_tick($urandom_range(0, 1) == 1);
    end
    set_pause(0);

    // Reset in CALC_Y discards the update; next tick starts cleanly from (0,0).
    frame_div = 2'd0; speed = 4'd7;
    @(negedge clk) vsync = 1'b1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    reset = 1'b1;
    #1;
    check_outputs("mid_reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("after_reset_busy", busy, 0);
    @(negedge clk) vsync = 1'b0;
    repeat (2) @(negedge clk);
    do_tick(0);
    check("clean_x", box_x, 7);
    check("clean_y", box_y, 7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got %0d checks expected completion", n_chk);
    $fatal(1);
  end

endmodule

// File: doc/box_motion_ctrl.md
# box_motion_ctrl

Per-frame motion sequencer for the bouncing-box VGA demo. Runs on the pixel clock beside `hvsync_generator`, detects each frame boundary on `vsync`, and walks a small FSM. The FSM time-shares one axis-update unit between X and Y, then commits the new box position and direction atomically. The pixel compositor reads `box_x`/`box_y`, and these never change mid-update. Speed, frame pacing, pause and single-step come from `ui_in`.

## Interface
- `H_RES`, 640, visible width in pixels
- `V_RES`, 480, visible height in pixels
- `SIZE`, 200, box edge length in pixels
- `POS_W`, 10, position width
- `SPD_W`, 4, speed width

- `clk`  in  1  pixel clock
- `reset`  in  1  asynchronous, active-high reset
- `vsync`  in  1  vsync from `hvsync_generator`; a rising edge is a frame tick
- `speed`  in  SPD_W  pixels moved per axis per update
- `frame_div`  in  2  updates occur every `frame_div`+1 frame ticks
- `pause`  in  1  level; suppresses normal updates
- `step`  in  1  one-cycle pulse; arms a single update while paused
- `box_x`, `box_y`  out  POS_W  top-left corner of the box
- `dir_x`, `dir_y`  out  1  0 = increasing (right/down), 1 = decreasing
- `bounce_x`, `bounce_y`  out  1  one-cycle pulse on commit when that axis reversed
- `busy`  out  1  high from CALC_X through COMMIT

## Operation
- Frame tick: `tick = vsync & ~vsync_q`. `vsync_q` is a register that resets to 1, so there is no spurious tick out of reset.
- Frame counter `fcnt` (2 bits):
  - When not paused, each tick increments it.
  - If the tick finds `fcnt >= frame_div`, an update launches and `fcnt` returns to 0.
  - Pause holds `fcnt`.
- Step:
  - `step` while `pause` = 1 sets `step_pend`.
  - A tick with `pause` = 1 and `step_pend` = 1 launches an update and clears `step_pend`.
  - `step_pend` clears whenever `pause` = 0.
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
  - IDLE → CALC_X on launch; `speed` is captured into `spd_r` at that edge.
  - CALC_X: runs the `box_axis_step` unit on (`box_x`, `dir_x`, `spd_r`, limit `H_RES-SIZE-1`) and registers `nx`, `ndx`, `bx`.
  - CALC_Y: runs the same unit on the Y operands with limit `V_RES-SIZE-1` and registers `ny`, `ndy`, `by`.
  - COMMIT → IDLE: loads `box_x`, `box_y`, `dir_x`, `dir_y`, `bounce_x` ← `bx`, `bounce_y` ← `by`.
- Ticks arriving outside IDLE are ignored and do not advance `fcnt`.
- Axis rule, computed at POS_W+1 bits, with limit L:
  - `spd` = 0: position and direction unchanged, no bounce.
  - dir = 0 and `pos + spd >= L`: pos ← L, dir ← 1, bounce.
  - dir = 0 otherwise: pos ← pos + spd.
  - dir = 1 and `pos <= spd`: pos ← 0, dir ← 0, bounce.
  - dir = 1 otherwise: pos ← pos − spd.
- With defaults, L = 439 for X and 279 for Y. A position never exceeds L and never underflows.
- Reset (async, any state, including mid-update):
  - `box_x` = `box_y` = 0, `dir_x` = `dir_y` = 0, bounces = 0, `busy` = 0.
  - State IDLE, `fcnt` = 0, `step_pend` = 0.
  - A partial update is discarded.

## Timing
- Let edge 0 be the clock edge at which IDLE sees a launching tick. Then:
  - edge 1: CALC_X → CALC_Y
  - edge 2: CALC_Y → COMMIT
  - edge 3: COMMIT → IDLE, outputs updated
- New positions are visible from edge 3, a latency of 3 cycles.
- `busy` is high from edge 0 to edge 3, 3 cycles.
- `bounce_*` are high from edge 3 to edge 4 only.
- X and Y always change on the same edge; the compositor never sees one axis updated without the other.
- `speed` changes after edge 0 do not affect the update in flight.
- `pause` is sampled only at the tick.

## Structure
- Shared package `vga_box_pkg`:
  - constants `H_RES`, `V_RES`, `SIZE`
  - derived `X_LIM`, `Y_LIM`
  - FSM state encoding (2 bits)
- Sub-module `box_axis_step`, purely combinational: inputs `pos`, `dir`, `spd`, `lim`; outputs `npos`, `ndir`, `bounce`. Instantiated once and multiplexed by state.
- Target size: roughly 150–200 lines total.

## Test plan
- Reset with `vsync` held high, speed = 5, `frame_div` = 0, one vsync rising edge → no update at the reset release, `box_x` = `box_y` = 5 exactly 3 cycles after the tick, `busy` high for 3 cycles.
- Start x = 435, `dir_x` = 0, speed = 5 → `box_x` = 439, `dir_x` = 1, `bounce_x` one-cycle pulse, `bounce_y` = 0.
- Start y = 3, `dir_y` = 1, speed = 3 → `box_y` = 0, `dir_y` = 0, `bounce_y` pulse; then speed = 0 → everything holds, no pulses.
- `frame_div` = 2, 9 ticks → exactly 3 updates, on ticks 3, 6 and 9.
- `pause` = 1, 4 ticks → no change; one `step` pulse then 2 ticks → exactly one update; `pause` = 0 clears any armed step.
- Assert `reset` during CALC_Y → outputs return to 0 and IDLE at once; the next tick performs a clean update from (0,0).
